msb_lsb_scan: RTL and testbench

Parametrised bit-position finder for the RSA/Montgomery datapath.
- Returns the index of the most-significant set bit of an operand (operand bit-length minus 1), or optionally the least-significant set bit.
- Scans CHUNK bits per clock, so area and latency can be traded off.
- Sits ahead of the Montgomery multiplier and exponentiator. It supplies the loop bound and the R = 2^k selection, and flags a zero operand explicitly.

---
 rtl/msb_lsb_scan.sv | 177 +++++++++++++++++
 tb/tb_msb_lsb_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/msb_lsb_scan.sv
// Multi-cycle finder for the most- or least-significant set bit of a wide operand, CHUNK bits per clock.
// Define MSB_LSB_SCAN_LZC_EN to add the leading/trailing-zero count output `cnt`.
module msb_lsb_scan #(
  parameter int WIDTH = 2048,
  parameter int CHUNK = 16,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    idx,
  output logic             zero
`ifdef MSB_LSB_SCAN_LZC_EN
  ,
  output logic [IW:0]      cnt
`endif
);

  localparam int SH = $clog2(CHUNK);
  localparam int CW = (CHUNK > 1) ? SH : 1;
  localparam int PW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0]                  ptr_q, ptr_d;
  logic [NCHUNK-1:0][CHUNK-1:0]   op_q, op_d;
  logic                           mode_q, mode_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           zero_q, zero_d;

  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    pos;
  logic [IW-1:0]    hit_idx;
  logic             hit;
  logic             last;

  // Single-cycle priority encoders over one chunk; the later loop match wins.
  function automatic logic [CW-1:0] hi_pos(input logic [CHUNK-1:0] c);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (c[i]) r = CW'(i);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] lo_pos(input logic [CHUNK-1:0] c);
    logic [CW-1:0] r;
    r = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) r = CW'(i);
    end
    return r;
  endfunction

  assign chunk   = op_q[ptr_q];
  assign hit     = |chunk;
  assign pos     = mode_q ? lo_pos(chunk) : hi_pos(chunk);
  assign hit_idx = (IW'(ptr_q) << SH) + IW'(pos);
  assign last    = mode_q ? (ptr_q == PTR_LAST) : (ptr_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (hit || last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == S_SCAN);
    done = (state_q == S_DONE);
    idx  = idx_q;
    zero = zero_q;
  end

  // Datapath next-state
  always_comb begin
    ptr_d  = ptr_q;
    op_d   = op_q;
    mode_d = mode_q;
    idx_d  = idx_q;
    zero_d = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = n;
          mode_d = mode;
          ptr_d  = mode ? '0 : PTR_LAST;
          zero_d = 1'b0;
        end
      end
      S_SCAN: begin
        if (hit) begin
          idx_d = hit_idx;
        end else if (last) begin
          idx_d  = '0;
          zero_d = 1'b1;
        end else begin
          ptr_d = mode_q ? ptr_q + PW'(1) : ptr_q - PW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      op_q   <= '0;
      mode_q <= 1'b0;
      idx_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      op_q   <= op_d;
      mode_q <= mode_d;
      idx_q  <= idx_d;
      zero_q <= zero_d;
    end
  end

`ifdef MSB_LSB_SCAN_LZC_EN
  localparam logic [IW:0] CNT_ALL = (IW + 1)'(WIDTH);
  localparam logic [IW:0] CNT_TOP = (IW + 1)'(WIDTH - 1);

  logic [IW:0] cnt_q, cnt_d;

  // Zero count follows idx: distance from the top in MSB mode, from bit 0 in LSB mode.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SCAN) begin
      if (hit) begin
        cnt_d = mode_q ? {1'b0, hit_idx} : CNT_TOP - {1'b0, hit_idx};
      end else if (last) begin
        cnt_d = CNT_ALL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_msb_lsb_scan.sv
// Bench for msb_lsb_scan: a 2048/16 instance and a 64/8 instance, checked against a bit-level reference model.
module tb_msb_lsb_scan;

  localparam int BW = 2048;
  localparam int BC = 16;
  localparam int SW = 64;
  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          sel = 1'b0;
  logic [BW-1:0] n_drv = '0;

  always #5 clk = ~clk;

  logic        b_start, b_busy, b_done, b_zero;
  logic [10:0] b_idx;
  logic        s_start, s_busy, s_done, s_zero;
  logic [5:0]  s_idx;
  logic [SW-1:0] s_n;
`ifdef MSB_LSB_SCAN_LZC_EN
  logic [11:0] b_cnt;
  logic [6:0]  s_cnt;
`endif

  assign b_start = start & ~sel;
  assign s_start = start & sel;
  assign s_n     = n_drv[SW-1:0];

  msb_lsb_scan #(.WIDTH(BW), .CHUNK(BC)) dut (
    .clk(clk), .rst(rst), .start(b_start), .mode(mode), .n(n_drv),
    .busy(b_busy), .done(b_done), .idx(b_idx), .zero(b_zero)
`ifdef MSB_LSB_SCAN_LZC_EN
    , .cnt(b_cnt)
`endif
  );

  msb_lsb_scan #(.WIDTH(SW), .CHUNK(SC)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .mode(mode), .n(s_n),
    .busy(s_busy), .done(s_done), .idx(s_idx), .zero(s_zero)
`ifdef MSB_LSB_SCAN_LZC_EN
    , .cnt(s_cnt)
`endif
  );

  logic        c_busy, c_done, c_zero;
  logic [11:0] c_idx, c_cnt;
  always_comb begin
    c_busy = sel ? s_busy : b_busy;
    c_done = sel ? s_done : b_done;
    c_zero = sel ? s_zero : b_zero;
    c_idx  = sel ? 12'(s_idx) : 12'(b_idx);
`ifdef MSB_LSB_SCAN_LZC_EN
    c_cnt  = sel ? 12'(s_cnt) : b_cnt;
`else
    c_cnt  = '0;
`endif
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: scan every bit for the extreme set bit, then derive chunks visited.
  task automatic model(input logic [BW-1:0] v, input logic m, input int w, input int c,
                       output int e_idx, output logic e_zero, output int e_k, output int e_cnt);
    int found;
    found = -1;
    for (int i = 0; i < w; i++) begin
      if (v[i] && (!m || found < 0)) found = i;
    end
    if (found < 0) begin
      e_zero = 1'b1; e_idx = 0; e_k = w / c; e_cnt = w;
    end else begin
      e_zero = 1'b0; e_idx = found;
      e_k   = m ? (found / c + 1) : (w / c - found / c);
      e_cnt = m ? found : (w - 1 - found);
    end
  endtask

  task automatic run(input string tag, input logic s, input logic m, input logic [BW-1:0] v, input bit hammer);
    int ei, ek, ec, cyc, busy_cnt, w, c;
    logic ez;
    bit seen;
    if (s) v[BW-1:SW] = '0;
    w = s ? SW : BW;
    c = s ? SC : BC;
    model(v, m, w, c, ei, ez, ek, ec);
    sel = s; mode = m; n_drv = v; start = 1'b1;
    @(negedge clk);
    start = hammer;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (c_busy) busy_cnt++;
      if (hammer) begin
        for (int j = 0; j < BW / 32; j++) n_drv[j*32 +: 32] = $urandom;
        mode = ~mode;
      end
      @(negedge clk);
      cyc++;
      if (c_done) seen = 1'b1;
    end
    chk({tag, ".done_seen"}, 32'(seen), 1);
    chk({tag, ".k"}, cyc, ek);
    chk({tag, ".busy_cycles"}, busy_cnt, ek);
    chk({tag, ".busy_at_done"}, 32'(c_busy), 0);
    chk({tag, ".idx"}, 32'(c_idx), ei);
    chk({tag, ".zero"}, 32'(c_zero), 32'(ez));
`ifdef MSB_LSB_SCAN_LZC_EN
    chk({tag, ".cnt"}, 32'(c_cnt), ec);
`endif
    @(negedge clk);
    chk({tag, ".done_once"}, 32'(c_done), 0);
    chk({tag, ".idle_after"}, 32'(c_busy), 0);
    start = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] v;
    int dn;
    logic s, m;

    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(b_busy), 0);
    chk("rst.done", 32'(b_done), 0);
    chk("rst.idx", 32'(b_idx), 0);
    chk("rst.zero", 32'(b_zero), 0);
    chk("rst.s_busy", 32'(s_busy), 0);
`ifdef MSB_LSB_SCAN_LZC_EN
    chk("rst.cnt", 32'(b_cnt), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    v = '0; v[2047] = 1'b1;
    run("msb_top", 1'b0, 1'b0, v, 1'b0);
    run("msb_one", 1'b0, 1'b0, 1, 1'b0);
    run("msb_zero", 1'b0, 1'b0, '0, 1'b0);
    v = '0; v[1023] = 1'b1; v[5] = 1'b1;
    run("msb_mid", 1'b0, 1'b0, v, 1'b0);
    run("lsb_mid", 1'b0, 1'b1, v, 1'b0);

    v = '0; v[3] = 1'b1;
    run("hammer", 1'b0, 1'b0, v, 1'b1);
    v = '0; v[100] = 1'b1; v[2000] = 1'b1;
    run("after_done", 1'b0, 1'b1, v, 1'b0);

    // Abort a long scan with reset partway through.
    sel = 1'b0; mode = 1'b0; n_drv = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort.busy_before", 32'(b_busy), 1);
    rst = 1'b1;
    #1;
    chk("abort.busy", 32'(b_busy), 0);
    chk("abort.done", 32'(b_done), 0);
    chk("abort.idx", 32'(b_idx), 0);
    chk("abort.zero", 32'(b_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (100) begin
      @(negedge clk);
      if (b_done) dn++;
    end
    chk("abort.no_done", dn, 0);
    run("post_rst", 1'b0, 1'b0, 'hF0, 1'b0);

    v = '0; v[63] = 1'b1;
    run("s_lsb_top", 1'b1, 1'b1, v, 1'b0);
    run("s_lsb_100", 1'b1, 1'b1, 'h100, 1'b0);
    run("s_msb_zero", 1'b1, 1'b0, '0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      v = '0;
      repeat ($urandom_range(0, 3)) v[$urandom_range(0, s ? SW - 1 : BW - 1)] = 1'b1;
      run("rand", s, m, v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
